pfe_coef_sequencer: RTL
=======================

# pfe_coef_sequencer

Clocked controller that owns the coefficient ports of a bank of `N_SEC` partial-fraction PWL filter sections, each implementing A/(s+B) plus its conjugate term. Requesters such as the CTLE/DFE adaptation loop and the gain-setting FSM select a stored coefficient profile. The block arbitrates between them round-robin, stages the selected profile section by section into a shadow bank, and validates stability. It then commits all sections to the active outputs in a single cycle, so the filter bank never sees a mixed profile, and holds a settle window before acknowledging.

## Interface
- `N_SEC`, 4, number of filter sections driven (1..8)
- `N_REQ`, 2, number of requesters (1..4)
- `N_PROF`, 4, number of stored profiles (power of 2)
- `SETTLE_CYC`, 8, clk cycles held after commit before `done` (>=1)
- `clk`  in  1  clock
- `rstn`  in  1  reset; one clock, reset asynchronous, active-low
- `cfg_we`  in  1  profile-table write strobe
- `cfg_rdy`  out  1  table writes accepted; low in LOAD
- `cfg_prof`  in  log2(N_PROF)  profile index for write
- `cfg_sec`  in  log2(N_SEC) (min 1)  section index for write
- `cfg_ar`, `cfg_ai`, `cfg_br`, `cfg_bi`  in  real  A/B value to store
- `req`  in  N_REQ  update request per requester (level)
- `req_prof`  in  N_REQ x log2(N_PROF)  requested profile per requester
- `gnt`  out  N_REQ  one-hot grant pulse (ARB cycle)
- `done`  out  N_REQ  one-hot completion pulse (DONE cycle)
- `err`  out  1  pulse with `done`: profile rejected, no commit
- `busy`  out  1  state != IDLE
- `upd`  out  1  pulse in COMMIT cycle
- `a_r`, `a_i`, `b_r`, `b_i`  out  N_SEC x real  active coefficients to sections

## Operation
- Profile table: N_PROF x N_SEC entries of {ar, ai, br, bi}, reset to {0,0,1,0}.
  - Write occurs at the clk edge when `cfg_we && cfg_rdy`.
  - `cfg_we` while `cfg_rdy`=0 is dropped.
- FSM states: IDLE, ARB, LOAD, COMMIT, SETTLE, DONE.
  - IDLE: if any `req` bit is set, go to ARB and latch winner and `req_prof[winner]`.
  - ARB: `gnt[winner]`=1 for one cycle; load counter `sec`=0, clear `bad`; go to LOAD.
  - LOAD: copy table[prof][sec] into shadow[sec], one section per cycle.
    - Set `bad` if that entry's `br` <= 0.0 (unstable pole).
    - After `sec`=N_SEC-1: go to COMMIT if !`bad`, else go to DONE.
  - COMMIT: copy active <= shadow for all sections in the same edge; `upd`=1; settle counter=0; go to SETTLE.
  - SETTLE: count to SETTLE_CYC-1, then go to DONE.
  - DONE: `done[winner]`=1 for one cycle; `err`=`bad`; go to IDLE.
- Arbitration is round-robin.
  - Priority starts at the index after the last winner.
  - After reset, the last winner is N_REQ-1, so requester 0 has first priority.
- Requests are sampled only in IDLE.
  - A `req` dropped mid-operation does not abort it; `done` still pulses.
  - A `req` still high in the DONE cycle is re-arbitrated from IDLE on the next cycle.
- An error leaves active coefficients unchanged; shadow contents are don't-care.
- Coefficient outputs are real and driven directly from the active registers.
- Conjugate handling: when A.i or B.i is nonzero, each section forms the conjugate term itself; the sequencer does not.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from `req` to outputs.
- Reset values:
  - state IDLE; `gnt`, `done`, `err`, `upd`, `busy` = 0; `cfg_rdy`=1.
  - Active and shadow coefficients {0,0,1,0}; table {0,0,1,0}.
  - `rstn` falling mid-operation forces this state immediately; no `done` is issued for the aborted operation.
- Latency, with e0 the edge that samples `req` in IDLE:
  - `gnt` is high after e0.
  - LOAD occupies e1..e(N_SEC).
  - COMMIT (`upd`) is high after e(N_SEC+1); active outputs change at e(N_SEC+2).
  - `done` is high after e(N_SEC+2+SETTLE_CYC).
  - IDLE is reached after e(N_SEC+3+SETTLE_CYC).
  - Defaults: `upd` after e5, `done` after e14; back-to-back throughput is one update per N_SEC+4+SETTLE_CYC cycles.
- Error path: DONE directly after the last LOAD; `done`+`err` high after e(N_SEC+1).
- Simultaneous `cfg_we` and IDLE->ARB: the write lands before LOAD reads (LOAD starts at e1).
- `cfg_rdy` is low exactly during LOAD cycles.

## Test plan
- Reset, write profile 1 with sections {A=(2,0),B=(1e9,0)}, req[0] with prof 1 -> `gnt[0]` after e0, `upd` after e5, `a_r[*]`=2.0 and `b_r[*]`=1e9 after e6, `done[0]` after e14, `err`=0.
- req[0] and req[1] both high continuously -> grants alternate 0,1,0,1; each `done` matches the preceding `gnt` index; period 16 cycles.
- Profile 2 with section 3 `br`=-1e8 -> `done`+`err` after e5, no `upd`, active coefficients unchanged from the previous profile.
- `cfg_we` during LOAD targeting the active profile -> `cfg_rdy`=0, write dropped, table readback unchanged; the same write in SETTLE is accepted.
- Assert `rstn`=0 in SETTLE -> outputs return to {0,0,1,0} without waiting for clk, `busy`=0, no `done` pulse; a new req after release completes normally.
- Complex profile A=(1,0.5), B=(2e9,3e9) -> `a_i`/`b_i` carry 0.5/3e9 after commit; the connected filter's output shows a damped oscillation and all sections update on the same edge.

Source files
------------

// File: rtl/pfe_coef_sequencer.sv
// Coefficient sequencer for a bank of partial-fraction PWL filter sections.
// Round-robin arbitrates profile update requests, stages the chosen profile
// into a shadow bank section by section, checks pole stability, then commits
// every section to the active outputs on one edge and holds a settle window.
module pfe_coef_sequencer #(
  parameter int unsigned N_SEC      = 4,
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned N_PROF     = 4,
  parameter int unsigned SETTLE_CYC = 8,
  localparam int unsigned PROF_W    = (N_PROF > 1) ? $clog2(N_PROF) : 1,
  localparam int unsigned SEC_W     = (N_SEC > 1) ? $clog2(N_SEC) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cfg_we,
  output logic                           cfg_rdy,
  input  logic [PROF_W-1:0]              cfg_prof,
  input  logic [SEC_W-1:0]               cfg_sec,
  input  real                            cfg_ar,
  input  real                            cfg_ai,
  input  real                            cfg_br,
  input  real                            cfg_bi,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0][PROF_W-1:0]   req_prof,
  output logic [N_REQ-1:0]               gnt,
  output logic [N_REQ-1:0]               done,
  output logic                           err,
  output logic                           busy,
  output logic                           upd,
  output real                            a_r [N_SEC],
  output real                            a_i [N_SEC],
  output real                            b_r [N_SEC],
  output real                            b_i [N_SEC]
);

  localparam int unsigned REQ_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_COMMIT, S_SETTLE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [REQ_W-1:0]   win_q, win_d;     // current winner, doubles as last winner
  logic [PROF_W-1:0]  prof_q, prof_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               bad_q, bad_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic               err_q, err_d, upd_q, upd_d, busy_q, busy_d, rdy_q, rdy_d;
  logic               found;
  logic [REQ_W-1:0]   cand;

  real tab_ar_q [N_PROF][N_SEC], tab_ar_d [N_PROF][N_SEC];
  real tab_ai_q [N_PROF][N_SEC], tab_ai_d [N_PROF][N_SEC];
  real tab_br_q [N_PROF][N_SEC], tab_br_d [N_PROF][N_SEC];
  real tab_bi_q [N_PROF][N_SEC], tab_bi_d [N_PROF][N_SEC];
  real shd_ar_q [N_SEC], shd_ar_d [N_SEC], shd_ai_q [N_SEC], shd_ai_d [N_SEC];
  real shd_br_q [N_SEC], shd_br_d [N_SEC], shd_bi_q [N_SEC], shd_bi_d [N_SEC];
  real act_ar_q [N_SEC], act_ar_d [N_SEC], act_ai_q [N_SEC], act_ai_d [N_SEC];
  real act_br_q [N_SEC], act_br_d [N_SEC], act_bi_q [N_SEC], act_bi_d [N_SEC];

  // Next-state, table write, staging/commit datapath and registered output decode
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    prof_d   = prof_q;
    sec_d    = sec_q;
    set_d    = set_q;
    bad_d    = bad_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    upd_d    = 1'b0;
    found    = 1'b0;
    cand     = '0;
    tab_ar_d = tab_ar_q;
    tab_ai_d = tab_ai_q;
    tab_br_d = tab_br_q;
    tab_bi_d = tab_bi_q;
    shd_ar_d = shd_ar_q;
    shd_ai_d = shd_ai_q;
    shd_br_d = shd_br_q;
    shd_bi_d = shd_bi_q;
    act_ar_d = act_ar_q;
    act_ai_d = act_ai_q;
    act_br_d = act_br_q;
    act_bi_d = act_bi_q;

    if (cfg_we && rdy_q && (int'(cfg_sec) < int'(N_SEC))) begin
      tab_ar_d[cfg_prof][cfg_sec] = cfg_ar;
      tab_ai_d[cfg_prof][cfg_sec] = cfg_ai;
      tab_br_d[cfg_prof][cfg_sec] = cfg_br;
      tab_bi_d[cfg_prof][cfg_sec] = cfg_bi;
    end

    case (state_q)
      S_IDLE: begin
        // Search starts one past the previous winner
        for (int i = 1; i <= int'(N_REQ); i++) begin
          cand = REQ_W'((int'(win_q) + i) % int'(N_REQ));
          if (!found && req[cand]) begin
            found = 1'b1;
            win_d = cand;
          end
        end
        if (found) begin
          prof_d        = req_prof[win_d];
          gnt_d[win_d]  = 1'b1;
          state_d       = S_ARB;
        end
      end
      S_ARB: begin
        sec_d   = '0;
        bad_d   = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shd_ar_d[sec_q] = tab_ar_q[prof_q][sec_q];
        shd_ai_d[sec_q] = tab_ai_q[prof_q][sec_q];
        shd_br_d[sec_q] = tab_br_q[prof_q][sec_q];
        shd_bi_d[sec_q] = tab_bi_q[prof_q][sec_q];
        if (tab_br_q[prof_q][sec_q] <= 0.0) bad_d = 1'b1;
        if (sec_q == SEC_W'(N_SEC - 1)) begin
          if (bad_d) begin
            done_d[win_q] = 1'b1;
            err_d         = 1'b1;
            state_d       = S_DONE;
          end else begin
            upd_d   = 1'b1;
            state_d = S_COMMIT;
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end
      S_COMMIT: begin
        act_ar_d = shd_ar_q;
        act_ai_d = shd_ai_q;
        act_br_d = shd_br_q;
        act_bi_d = shd_bi_q;
        set_d    = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          done_d[win_q] = 1'b1;
          err_d         = bad_q;
          state_d       = S_DONE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d != S_LOAD);
  end

  // State, table and coefficient registers; reset restores the {0,0,1,0} defaults
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      win_q   <= REQ_W'(N_REQ - 1);
      prof_q  <= '0;
      sec_q   <= '0;
      set_q   <= '0;
      bad_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      for (int p = 0; p < int'(N_PROF); p++) begin
        for (int s = 0; s < int'(N_SEC); s++) begin
          tab_ar_q[p][s] <= 0.0;
          tab_ai_q[p][s] <= 0.0;
          tab_br_q[p][s] <= 1.0;
          tab_bi_q[p][s] <= 0.0;
        end
      end
      for (int s = 0; s < int'(N_SEC); s++) begin
        shd_ar_q[s] <= 0.0;
        shd_ai_q[s] <= 0.0;
        shd_br_q[s] <= 1.0;
        shd_bi_q[s] <= 0.0;
        act_ar_q[s] <= 0.0;
        act_ai_q[s] <= 0.0;
        act_br_q[s] <= 1.0;
        act_bi_q[s] <= 0.0;
      end
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      prof_q   <= prof_d;
      sec_q    <= sec_d;
      set_q    <= set_d;
      bad_q    <= bad_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      tab_ar_q <= tab_ar_d;
      tab_ai_q <= tab_ai_d;
      tab_br_q <= tab_br_d;
      tab_bi_q <= tab_bi_d;
      shd_ar_q <= shd_ar_d;
      shd_ai_q <= shd_ai_d;
      shd_br_q <= shd_br_d;
      shd_bi_q <= shd_bi_d;
      act_ar_q <= act_ar_d;
      act_ai_q <= act_ai_d;
      act_br_q <= act_br_d;
      act_bi_q <= act_bi_d;
    end
  end

  assign cfg_rdy = rdy_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign upd     = upd_q;
  assign a_r     = act_ar_q;
  assign a_i     = act_ai_q;
  assign b_r     = act_br_q;
  assign b_i     = act_bi_q;

endmodule
